memory_controller: RTL

Single owner of the byte-wide RAM/IO port. It arbitrates between the instruction-fetch unit and the load/store buffer, sequences multi-byte loads and stores one byte per cycle, and broadcasts load results on the mem_data_ready/mem_data/mem_id bus that the LSB, RS and ROB snoop. It also supplies the mem_busy back-pressure the LSB checks before it dequeues.

---
 rtl/memory_controller_pkg.sv | 46 ++++
 rtl/memory_controller_load_data_extend.sv | 24 ++
 rtl/memory_controller.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_pkg.sv
// memory_controller_pkg
//   Shared widths, op codes, IO addresses and FSM state type for the
//   memory controller slice, plus small op-decoding helpers.
package memory_controller_pkg;

  localparam int XLEN           = 32;
  localparam int INST_OP_WIDTH  = 6;
  localparam int ROB_SIZE_WIDTH = 4;

  // UART data/status ports; stores here stall while the UART buffer is full.
  localparam logic [XLEN-1:0] IO_ADDR0 = 32'h0003_0000;
  localparam logic [XLEN-1:0] IO_ADDR1 = 32'h0003_0004;

  localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd10;
  localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd11;
  localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd12;
  localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 6'd13;
  localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 6'd14;
  localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd15;
  localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd16;
  localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IFETCH,
    ST_LOAD,
    ST_STORE
  } state_t;

  function automatic logic op_is_load(input logic [INST_OP_WIDTH-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic [2:0] op_nbytes(input logic [INST_OP_WIDTH-1:0] op);
    logic [2:0] n;
    case (op)
      OP_LB, OP_LBU, OP_SB: n = 3'd1;
      OP_LH, OP_LHU, OP_SH: n = 3'd2;
      OP_LW, OP_SW:         n = 3'd4;
      default:              n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/memory_controller_load_data_extend.sv
// memory_controller_load_data_extend
//   Combinational sign/zero extension of an assembled little-endian load.
//   op       : load op code (LB/LH sign-extend, LBU/LHU zero-extend)
//   data_in  : assembled bytes, byte 0 in [7:0]
//   data_out : extended result (word loads pass through)
module memory_controller_load_data_extend
  import memory_controller_pkg::*;
(
  input  logic [INST_OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]          data_in,
  output logic [XLEN-1:0]          data_out
);

  always_comb begin
    case (op)
      OP_LB:   data_out = {{24{data_in[7]}}, data_in[7:0]};
      OP_LBU:  data_out = {24'b0, data_in[7:0]};
      OP_LH:   data_out = {{16{data_in[15]}}, data_in[15:0]};
      OP_LHU:  data_out = {16'b0, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/memory_controller.sv
// memory_controller
//   Owns the byte-wide RAM/IO port. Round-robin arbitration between
//   instruction fetch and the LSB, one byte per cycle, load results broadcast
//   on mem_data_ready/mem_data/mem_id.
//   clk, rst (sync, active-high), rdy (global enable), flush (mispredict)
//   if_req/if_addr -> if_ready/if_inst      : word fetch
//   lsb_mem_*      -> mem_data_ready/...    : LSB load/store, mem_busy back-pressure
//   mem_din/mem_dout/mem_a/mem_wr           : RAM port, io_buffer_full stalls IO stores
//
//   state  | meaning
//   IDLE   | arbitrate, bus idle
//   IFETCH | reading 4 instruction bytes
//   LOAD   | reading 1/2/4 load bytes
//   STORE  | writing 1/2/4 store bytes
module memory_controller
  import memory_controller_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      if_req,
  input  logic [XLEN-1:0]           if_addr,
  output logic                      if_ready,
  output logic [XLEN-1:0]           if_inst,
  input  logic                      lsb_mem_enable,
  input  logic [INST_OP_WIDTH-1:0]  lsb_mem_op,
  input  logic [XLEN-1:0]           lsb_mem_addr,
  input  logic [XLEN-1:0]           lsb_mem_data,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id,
  output logic                      mem_busy,
  output logic                      mem_data_ready,
  output logic [XLEN-1:0]           mem_data,
  output logic [ROB_SIZE_WIDTH-1:0] mem_id,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full
);

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [INST_OP_WIDTH-1:0]  op_q, op_d;
  logic [XLEN-1:0]           addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
  logic [ROB_SIZE_WIDTH-1:0] id_q, id_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [INST_OP_WIDTH-1:0]  pend_op_q, pend_op_d;
  logic [XLEN-1:0]           pend_addr_q, pend_addr_d, pend_data_q, pend_data_d;
  logic [ROB_SIZE_WIDTH-1:0] pend_id_q, pend_id_d;
  logic                      lsb_turn_q, lsb_turn_d;
  logic                      if_ready_q, if_ready_d, mem_data_ready_q, mem_data_ready_d;
  logic [XLEN-1:0]           if_inst_q, if_inst_d, mem_data_q, mem_data_d;
  logic [ROB_SIZE_WIDTH-1:0] mem_id_q, mem_id_d;

  logic [INST_OP_WIDTH-1:0]  cand_op;
  logic [XLEN-1:0]           cand_addr, cand_data, buf_merged, ext_data;
  logic [ROB_SIZE_WIDTH-1:0] cand_id;
  logic [2:0]                nbytes;
  logic                      lsb_avail, if_avail, grant_lsb, grant_fetch;
  logic                      io_stall, issue_rd, issue_wr;

  // An LSB request arriving this cycle competes as if it were already pending.
  assign cand_op   = pend_valid_q ? pend_op_q   : lsb_mem_op;
  assign cand_addr = pend_valid_q ? pend_addr_q : lsb_mem_addr;
  assign cand_data = pend_valid_q ? pend_data_q : lsb_mem_data;
  assign cand_id   = pend_valid_q ? pend_id_q   : lsb_mem_id;

  assign lsb_avail = (pend_valid_q | lsb_mem_enable) & ~(flush & op_is_load(cand_op));
  // The fetch unit only drops if_req after seeing if_ready, so the request is
  // still up during the if_ready cycle and must not be granted a second time.
  assign if_avail  = if_req & ~flush & ~if_ready_q;

  assign nbytes   = op_nbytes(op_q);
  assign io_stall = (state_q == ST_STORE) & io_buffer_full &
                    ((addr_q == IO_ADDR0) | (addr_q == IO_ADDR1));
  assign issue_rd = ((state_q == ST_IFETCH) | (state_q == ST_LOAD)) & (cnt_q < nbytes);
  assign issue_wr = (state_q == ST_STORE) & ~io_stall;

  assign mem_a    = (issue_rd | issue_wr) ? addr_q + {29'b0, cnt_q} : 32'b0;
  assign mem_wr   = issue_wr;
  assign mem_busy = pend_valid_q | lsb_mem_enable | (state_q == ST_LOAD) | (state_q == ST_STORE);

  always_comb begin
    mem_dout = 8'b0;
    if (issue_wr) begin
      case (cnt_q[1:0])
        2'd0: mem_dout = wdata_q[7:0];
        2'd1: mem_dout = wdata_q[15:8];
        2'd2: mem_dout = wdata_q[23:16];
        default: mem_dout = wdata_q[31:24];
      endcase
    end
  end

  // mem_din holds the byte addressed in the previous cycle, i.e. byte cnt-1.
  always_comb begin
    buf_merged = buf_q;
    case (cnt_q)
      3'd1: buf_merged[7:0]   = mem_din;
      3'd2: buf_merged[15:8]  = mem_din;
      3'd3: buf_merged[23:16] = mem_din;
      3'd4: buf_merged[31:24] = mem_din;
      default: ;
    endcase
  end

  memory_controller_load_data_extend u_extend (
    .op       (op_q),
    .data_in  (buf_merged),
    .data_out (ext_data)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    op_d             = op_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    id_d             = id_q;
    buf_d            = buf_q;
    lsb_turn_d       = lsb_turn_q;
    if_ready_d       = 1'b0;
    if_inst_d        = if_inst_q;
    mem_data_ready_d = 1'b0;
    mem_data_d       = mem_data_q;
    mem_id_d         = mem_id_q;
    pend_valid_d     = pend_valid_q;
    pend_op_d        = pend_op_q;
    pend_addr_d      = pend_addr_q;
    pend_data_d      = pend_data_q;
    pend_id_d        = pend_id_q;
    grant_lsb        = 1'b0;
    grant_fetch      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // lsb_turn_q resets low, so fetch wins the first contention after reset.
        if (lsb_avail && (!if_avail || lsb_turn_q)) grant_lsb = 1'b1;
        else if (if_avail)                          grant_fetch = 1'b1;
        if (grant_fetch) begin
          state_d    = ST_IFETCH;
          op_d       = OP_LW;
          addr_d     = if_addr;
          cnt_d      = 3'd0;
          buf_d      = '0;
          lsb_turn_d = 1'b1;
        end else if (grant_lsb) begin
          state_d    = op_is_load(cand_op) ? ST_LOAD : ST_STORE;
          op_d       = cand_op;
          addr_d     = cand_addr;
          wdata_d    = cand_data;
          id_d       = cand_id;
          cnt_d      = 3'd0;
          buf_d      = '0;
          lsb_turn_d = 1'b0;
        end
      end
      ST_IFETCH, ST_LOAD: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) buf_d = buf_merged;
          if (cnt_q == nbytes) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            if (state_q == ST_IFETCH) begin
              if_ready_d = 1'b1;
              if_inst_d  = buf_merged;
            end else begin
              mem_data_ready_d = 1'b1;
              mem_data_d       = ext_data;
              mem_id_d         = id_q;
            end
          end
        end
      end
      ST_STORE: begin
        // Stores are already committed, so flush does not touch them.
        if (!io_stall) begin
          if (cnt_q == nbytes - 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush && pend_valid_q && op_is_load(pend_op_q)) pend_valid_d = 1'b0;
    if (grant_lsb) pend_valid_d = 1'b0;
    if (lsb_mem_enable && !(grant_lsb && !pend_valid_q) &&
        !(flush && op_is_load(lsb_mem_op))) begin
      pend_valid_d = 1'b1;
      pend_op_d    = lsb_mem_op;
      pend_addr_d  = lsb_mem_addr;
      pend_data_d  = lsb_mem_data;
      pend_id_d    = lsb_mem_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 3'd0;
      op_q             <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      id_q             <= '0;
      buf_q            <= '0;
      lsb_turn_q       <= 1'b0;
      if_ready_q       <= 1'b0;
      if_inst_q        <= '0;
      mem_data_ready_q <= 1'b0;
      mem_data_q       <= '0;
      mem_id_q         <= '0;
      pend_valid_q     <= 1'b0;
      pend_op_q        <= '0;
      pend_addr_q      <= '0;
      pend_data_q      <= '0;
      pend_id_q        <= '0;
    end else if (rdy) begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      op_q             <= op_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      id_q             <= id_d;
      buf_q            <= buf_d;
      lsb_turn_q       <= lsb_turn_d;
      if_ready_q       <= if_ready_d;
      if_inst_q        <= if_inst_d;
      mem_data_ready_q <= mem_data_ready_d;
      mem_data_q       <= mem_data_d;
      mem_id_q         <= mem_id_d;
      pend_valid_q     <= pend_valid_d;
      pend_op_q        <= pend_op_d;
      pend_addr_q      <= pend_addr_d;
      pend_data_q      <= pend_data_d;
      pend_id_q        <= pend_id_d;
    end
  end

  assign if_ready       = if_ready_q;
  assign if_inst        = if_inst_q;
  assign mem_data_ready = mem_data_ready_q;
  assign mem_data       = mem_data_q;
  assign mem_id         = mem_id_q;

endmodule
